invaders_int_ctrl: RTL
======================

Name: invaders_int_ctrl

Overview:
- Interrupt responder for the 8080 system bus; the device end of the CPU's INTA handshake.
- Generates mid-frame (RST 1, 0xCF) and end-of-frame (RST 2, 0xD7) interrupts from a CPU-clock frame counter.
- Drives `iint` high while any interrupt is pending.
- Supplies the RST opcode on the shared data bus during the CPU's interrupt-acknowledge fetch.

Parameters:
- FRAME_CYCLES, 33333: CPU clocks per video frame (2 MHz / 60 Hz). Must be ≥ 4.
- MID_CYCLE, 16667: counter value that raises the mid-frame interrupt. Must satisfy 0 < MID_CYCLE < FRAME_CYCLES-1.
- CNT_WIDTH, 16: frame counter width. Must satisfy 2^CNT_WIDTH ≥ FRAME_CYCLES.

Ports:
- clk  input  1  CPU clock
- rst_n  input  1  asynchronous active-low reset
- sync  input  1  CPU SYNC: the status word is on `data` this cycle
- dbin  input  1  CPU data-in strobe
- data  inout  8  shared tri-state data bus; high-Z unless responding
- iint  output  1  interrupt request to the CPU
- frame_start  output  1  one-clock pulse when the counter wraps to 0

Behaviour:
- Reset values (asynchronous, immediate): counter=0, both pending flags=0, inta_cycle=0, sel=0, iint=0, frame_start=0, data=high-Z. Reset during an INTA fetch releases the bus at once.
- Frame counter:
  - Increments every clk and wraps FRAME_CYCLES-1 → 0.
  - frame_start=1 in the clock after the wrap, registered, i.e. while count==0.
- Event raising:
  - count==MID_CYCLE sets pend_mid.
  - count==FRAME_CYCLES-1 sets pend_end.
  - Each flag is set on the clock edge that leaves that count value.
- iint = pend_mid | pend_end, registered from the flags (no combinational path from bus inputs).
- Status decode:
  - On a clk edge with sync=1, inta_cycle <= data[0] (8080 status bit D0 = INTA).
  - On that same edge, if data[0]=1: sel <= pend_end ? END : MID. End-of-frame has priority, and the choice is frozen for the whole cycle.
  - Each later sync re-evaluates inta_cycle.
- Bus drive:
  - data = (inta_cycle & dbin) ? opcode(sel) : 8'hzz. This is combinational from registered state and dbin.
  - opcode(MID)=0xCF, opcode(END)=0xD7.
- Acknowledge/clear:
  - The selected flag clears on the first clk edge where dbin=0 after dbin was 1 during inta_cycle.
  - inta_cycle also clears on that edge.
  - Only one flag clears per acknowledge.
- Simultaneous set and clear of the same flag: set wins and the flag stays pending.
- Re-raise while a flag is already pending: the flag stays 1 and the event is lost (see optional feature).
- INTA with no flag pending (spurious): drive 0xD7 and clear nothing.
- The block never drives `data` outside `inta_cycle & dbin`. Memory/IO responders must be disabled by the top level while inta_cycle.

Optional Feature:
- Macro: INVADERS_INT_MISS_CNT_EN.
- Defined:
  - Adds output miss_count[7:0], reset 0.
  - Increments, saturating at 0xFF, whenever an event raise finds its flag already set.
  - If both flags miss in the same clock it increments by 2, still saturating.
- Undefined: the port and counter are absent and missed events are silently dropped.

Decomposition:
- Package invaders_pkg:
  - status bit indices (STAT_INTA=0, STAT_WO_N=1, STAT_STACK=2, STAT_HLTA=3, STAT_OUT=4, STAT_M1=5, STAT_INP=6, STAT_MEMR=7)
  - RST_MID_OP=8'hCF, RST_END_OP=8'hD7
  - enum int_sel_t {MID, END}
- One natural sub-module, invaders_frame_timer: counter, wrap, and single-cycle mid/end/frame_start strobes. invaders_int_ctrl keeps the flags, status decode and bus drive.

Test Plan (FRAME_CYCLES=100, MID_CYCLE=50):
- Reset release, idle 49 clocks → iint=0, data=Z. Edge leaving count 50 → pend_mid=1 and iint=1 one clock later. Wrap → frame_start high for exactly 1 clk.
- pend_mid only, then sync with data=8'hA3 (M1|INTA|...), then dbin high 2 clks → data=8'hCF while dbin=1. Once dbin falls → data=Z, pend_mid=0, iint=0.
- Both pending at INTA sync → 0xD7 driven and pend_end cleared, iint stays 1. Second INTA → 0xCF, then iint=0.
- Non-INTA sync (data=8'hA2) with pend_end=1, dbin high → data stays Z and the flag is unchanged.
- Assert rst_n=0 mid-dbin of an INTA fetch → data=Z within the same cycle, iint=0, counter=0.
- Macro defined: no acknowledge for 3 frames → miss_count=4 (2 mid + 2 end re-raises). Forcing 300 misses → miss_count=0xFF.

Source files
------------

// File: rtl/invaders_pkg.sv
// invaders_pkg: shared constants for the Space Invaders interrupt responder.
// 8080 status-word bit positions, the two RST opcodes and the interrupt
// source selector used by invaders_int_ctrl.
package invaders_pkg;

    // 8080 status word bit positions (valid on the data bus while SYNC=1)
    localparam int STAT_INTA  = 0;
    localparam int STAT_WO_N  = 1;
    localparam int STAT_STACK = 2;
    localparam int STAT_HLTA  = 3;
    localparam int STAT_OUT   = 4;
    localparam int STAT_M1    = 5;
    localparam int STAT_INP   = 6;
    localparam int STAT_MEMR  = 7;

    // RST 1 (mid-frame) and RST 2 (end-of-frame) opcodes
    localparam logic [7:0] RST_MID_OP = 8'hCF;
    localparam logic [7:0] RST_END_OP = 8'hD7;

    typedef enum logic {
        MID = 1'b0,
        END = 1'b1
    } int_sel_t;

    // Opcode placed on the bus for a given interrupt source
    function automatic logic [7:0] rst_opcode(input int_sel_t s);
        return (s == END) ? RST_END_OP : RST_MID_OP;
    endfunction

endpackage

// File: rtl/invaders_frame_timer.sv
// invaders_frame_timer: free-running CPU-clock frame counter.
// Counts 0 .. FRAME_CYCLES-1 and wraps. mid_hit / end_hit are true while the
// counter sits on MID_CYCLE / FRAME_CYCLES-1, so a flag loaded from them is
// set on the edge that leaves that count. frame_start is registered and is
// high while the counter is 0 after a wrap (not in the first cycle after reset).
// Parameter constraints: FRAME_CYCLES >= 4, 0 < MID_CYCLE < FRAME_CYCLES-1,
// 2**CNT_WIDTH >= FRAME_CYCLES.
module invaders_frame_timer #(
    parameter int FRAME_CYCLES = 33333,
    parameter int MID_CYCLE    = 16667,
    parameter int CNT_WIDTH    = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic mid_hit,
    output logic end_hit,
    output logic frame_start
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(FRAME_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] MID_CNT  = CNT_WIDTH'(MID_CYCLE);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] count;

    assign mid_hit = (count == MID_CNT);
    assign end_hit = (count == LAST_CNT);

    // Frame counter: increment every clock, wrap after the last cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (end_hit) begin
            count <= '0;
        end else begin
            count <= count + ONE_CNT;
        end
    end

    // Frame-start strobe: registered from the wrap so it is high while count==0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= end_hit;
        end
    end

endmodule

// File: rtl/invaders_int_ctrl.sv
// invaders_int_ctrl: 8080 interrupt responder for the Space Invaders board.
// Raises RST 1 at mid-frame and RST 2 at end-of-frame, holds iint while either
// is pending, and answers the CPU's interrupt-acknowledge fetch by driving the
// RST opcode onto the shared data bus.
// Optional build macro: INVADERS_INT_MISS_CNT_EN adds miss_count[7:0], a
// saturating count of events that arrived while their flag was still pending.
//
// Bus handshake: a status word is valid on `data` on any clock edge where
// sync=1; its INTA bit opens an acknowledge cycle. Within that cycle the CPU
// reads while dbin=1 and the block drives the opcode exactly while
// inta_cycle & dbin. The first edge with dbin=0 after dbin was seen high
// completes the transfer: the selected flag clears and the cycle closes.
// There is no back-pressure; the responder is always ready.
module invaders_int_ctrl
    import invaders_pkg::*;
#(
    parameter int FRAME_CYCLES = 33333,
    parameter int MID_CYCLE    = 16667,
    parameter int CNT_WIDTH    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync,
    input  logic       dbin,
    inout  wire  [7:0] data,
    output logic       iint,
    output logic       frame_start
`ifdef INVADERS_INT_MISS_CNT_EN
    ,
    output logic [7:0] miss_count
`endif
);

    logic     mid_hit;
    logic     end_hit;
    logic     pend_mid;
    logic     pend_end;
    logic     inta_cycle;
    logic     dbin_seen;
    logic     ack_armed;
    int_sel_t sel;
    logic     ack_done;
    logic     clr_mid;
    logic     clr_end;

    invaders_frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES),
        .MID_CYCLE    (MID_CYCLE),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .mid_hit     (mid_hit),
        .end_hit     (end_hit),
        .frame_start (frame_start)
    );

    // Only the INTA bit of the status word matters to this block
    wire unused_status = &{1'b0, data[7:1]};

    // The acknowledge completes on the first dbin-low edge after a read strobe
    assign ack_done = inta_cycle & dbin_seen & ~dbin;
    // A spurious acknowledge (nothing pending at status time) clears nothing
    assign clr_mid  = ack_done & ack_armed & (sel == MID);
    assign clr_end  = ack_done & ack_armed & (sel == END);

    // Pending flags: a raise on the same edge as a clear wins; iint lags one clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_mid <= 1'b0;
            pend_end <= 1'b0;
            iint     <= 1'b0;
        end else begin
            pend_mid <= mid_hit | (pend_mid & ~clr_mid);
            pend_end <= end_hit | (pend_end & ~clr_end);
            iint     <= pend_mid | pend_end;
        end
    end

    // Status decode and acknowledge tracking; source choice is frozen at sync
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inta_cycle <= 1'b0;
            dbin_seen  <= 1'b0;
            ack_armed  <= 1'b0;
            sel        <= MID;
        end else if (sync) begin
            inta_cycle <= data[STAT_INTA];
            dbin_seen  <= 1'b0;
            if (data[STAT_INTA]) begin
                // End-of-frame has priority; with nothing pending answer RST 2
                sel       <= (pend_end || !pend_mid) ? END : MID;
                ack_armed <= pend_mid | pend_end;
            end
        end else if (ack_done) begin
            inta_cycle <= 1'b0;
            dbin_seen  <= 1'b0;
        end else if (inta_cycle && dbin) begin
            dbin_seen <= 1'b1;
        end
    end

    // Bus drive: opcode only while the CPU is reading inside an acknowledge
    assign data = (inta_cycle & dbin) ? rst_opcode(sel) : 8'hzz;

`ifdef INVADERS_INT_MISS_CNT_EN
    logic [1:0] miss_inc;
    logic [8:0] miss_sum;

    assign miss_inc = {1'b0, mid_hit & pend_mid} + {1'b0, end_hit & pend_end};
    assign miss_sum = {1'b0, miss_count} + {7'b0, miss_inc};

    // Lost-event counter, saturating at 0xFF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_count <= 8'h00;
        end else begin
            miss_count <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
        end
    end
`endif

endmodule
